// File: rtl/risc_mips_pkg.sv
// Shared ISA definitions for the five-stage MIPS-like pipeline: opcodes,
// instruction classes, field positions and the operand-forwarding selector.
package risc_mips_pkg;

   localparam logic [5:0] OpAdd   = 6'b000000;
   localparam logic [5:0] OpSub   = 6'b000001;
   localparam logic [5:0] OpAnd   = 6'b000010;
   localparam logic [5:0] OpOr    = 6'b000011;
   localparam logic [5:0] OpSlt   = 6'b000100;
   localparam logic [5:0] OpMul   = 6'b000101;
   localparam logic [5:0] OpLw    = 6'b001000;
   localparam logic [5:0] OpSw    = 6'b001001;
   localparam logic [5:0] OpAddi  = 6'b001010;
   localparam logic [5:0] OpSubi  = 6'b001011;
   localparam logic [5:0] OpSlti  = 6'b001100;
   localparam logic [5:0] OpBneqz = 6'b001101;
   localparam logic [5:0] OpBeqz  = 6'b001110;
   localparam logic [5:0] OpHlt   = 6'b111111;

   // Instruction word field positions
   localparam int unsigned OpcodeHi = 31;
   localparam int unsigned OpcodeLo = 26;
   localparam int unsigned RsLo     = 21;
   localparam int unsigned RtLo     = 16;
   localparam int unsigned RdLo     = 11;
   localparam int unsigned ImmHi    = 15;
   localparam int unsigned ImmLo    = 0;

   // NOP is first so an all-zero pipeline register decodes as a bubble
   typedef enum logic [2:0] {
      NOP,
      RR_ALU,
      RM_ALU,
      LOAD,
      STORE,
      BRANCH,
      HALT
   } itype_e;

   typedef enum logic [1:0] {
      FwdNone,
      FwdExMem,
      FwdMemWb
   } fwd_e;

   function automatic itype_e decode_itype(input logic [5:0] op);
      itype_e t;
      case (op)
         OpAdd, OpSub, OpAnd, OpOr, OpSlt, OpMul: t = RR_ALU;
         OpAddi, OpSubi, OpSlti:                  t = RM_ALU;
         OpLw:                                    t = LOAD;
         OpSw:                                    t = STORE;
         OpBneqz, OpBeqz:                         t = BRANCH;
         OpHlt:                                   t = HALT;
         default:                                 t = NOP;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/risc_mips_pipe_if.sv
// Instruction and data memory bus of the pipeline. The core is the master,
// the memories are the slave; both memories answer combinationally.
interface risc_mips_pipe_if #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned AW   = 10
);
   logic [AW-1:0]   imem_addr;
   logic [31:0]     imem_rdata;
   logic [AW-1:0]   dmem_addr;
   logic [XLEN-1:0] dmem_wdata;
   logic            dmem_we;
   logic [XLEN-1:0] dmem_rdata;

   modport master (
      output imem_addr,
      input  imem_rdata,
      output dmem_addr,
      output dmem_wdata,
      output dmem_we,
      input  dmem_rdata
   );

   modport slave (
      input  imem_addr,
      output imem_rdata,
      input  dmem_addr,
      input  dmem_wdata,
      input  dmem_we,
      output dmem_rdata
   );
endinterface

// File: rtl/risc_mips_hazard.sv
// Combinational hazard unit: EX operand forwarding selects, load-use stall
// and taken-branch flush.
module risc_mips_hazard
   import risc_mips_pkg::*;
#(
   parameter int unsigned RIW = 5
) (
   input  logic [RIW-1:0] id_rs,
   input  logic [RIW-1:0] id_rt,
   input  logic           id_use_rs,
   input  logic           id_use_rt,
   input  logic           ex_load,
   input  logic           ex_wr,
   input  logic [RIW-1:0] ex_dst,
   input  logic [RIW-1:0] ex_rs,
   input  logic [RIW-1:0] ex_rt,
   input  logic           mem_wr,
   input  logic [RIW-1:0] mem_dst,
   input  logic           wb_wr,
   input  logic [RIW-1:0] wb_dst,
   input  logic           ex_taken,
   output fwd_e           fwd_a,
   output fwd_e           fwd_b,
   output logic           stall,
   output logic           flush
);

   // Forward selects; the EX/MEM result is younger, so it wins over MEM/WB
   always_comb begin
      fwd_a = FwdNone;
      fwd_b = FwdNone;
      if (mem_wr && (mem_dst == ex_rs)) begin
         fwd_a = FwdExMem;
      end else if (wb_wr && (wb_dst == ex_rs)) begin
         fwd_a = FwdMemWb;
      end
      if (mem_wr && (mem_dst == ex_rt)) begin
         fwd_b = FwdExMem;
      end else if (wb_wr && (wb_dst == ex_rt)) begin
         fwd_b = FwdMemWb;
      end
   end

   // Load-use stall and branch flush; a taken branch in EX is never a load
   always_comb begin
      flush = ex_taken;
      stall = !ex_taken && ex_load && ex_wr &&
              ((id_use_rs && (id_rs == ex_dst)) || (id_use_rt && (id_rt == ex_dst)));
   end

endmodule

// File: rtl/risc_mips_pipe.sv
// Five-stage (IF/ID/EX/MEM/WB) MIPS-like core with full forwarding,
// single-bubble load-use stall, EX-resolved branches and a sticky halt.
module risc_mips_pipe
   import risc_mips_pkg::*;
#(
   parameter int unsigned XLEN = 32,
   parameter int unsigned NREG = 32,
   parameter int unsigned AW   = 10
) (
   input  logic             CLK,
   input  logic             RST,
   risc_mips_pipe_if.master bus,
   output logic             halted,
   output logic [AW-1:0]    pc_out,
   input  logic [4:0]       dbg_rsel,
   output logic [XLEN-1:0]  dbg_rdata
);

   localparam int unsigned RIW = $clog2(NREG);

   typedef struct packed {
      logic          valid;
      logic [31:0]   instr;
      logic [AW-1:0] npc;
   } ifid_t;

   typedef struct packed {
      itype_e          itype;
      logic [5:0]      opcode;
      logic [RIW-1:0]  rs;
      logic [RIW-1:0]  rt;
      logic [RIW-1:0]  dst;
      logic            wr;
      logic [XLEN-1:0] a;
      logic [XLEN-1:0] b;
      logic [XLEN-1:0] imm;
      logic [AW-1:0]   npc;
   } idex_t;

   typedef struct packed {
      itype_e          itype;
      logic            wr;
      logic [RIW-1:0]  dst;
      logic [XLEN-1:0] alu;
      logic [XLEN-1:0] sdata;
   } exmem_t;

   typedef struct packed {
      itype_e          itype;
      logic            wr;
      logic [RIW-1:0]  dst;
      logic [XLEN-1:0] result;
   } memwb_t;

   localparam ifid_t  IfidBubble  = '{default: '0};
   localparam idex_t  IdexBubble  = '{itype: NOP, default: '0};
   localparam exmem_t ExmemBubble = '{itype: NOP, default: '0};
   localparam memwb_t MemwbBubble = '{itype: NOP, default: '0};

   logic [AW-1:0]   pc_q, pc_d;
   ifid_t           ifid_q, ifid_d;
   idex_t           idex_q, idex_d;
   exmem_t          exmem_q, exmem_d;
   memwb_t          memwb_q, memwb_d;
   logic            stop_q, stop_d;
   logic            halted_q;
   logic [XLEN-1:0] regs_q [NREG];

   // ID stage signals
   logic [5:0]      id_op;
   logic [RIW-1:0]  id_rs, id_rt, id_rd, id_dst;
   itype_e          id_itype;
   logic            id_wr, id_use_rs, id_use_rt, id_is_hlt;
   logic [XLEN-1:0] id_a, id_b, id_imm;
   idex_t           id_dec;

   // EX / MEM / WB stage signals
   fwd_e            fwd_a, fwd_b;
   logic            stall, flush;
   logic [XLEN-1:0] ex_a, ex_b, ex_op2, ex_alu;
   logic            ex_taken;
   logic [AW-1:0]   ex_target;
   logic [XLEN-1:0] mem_result;
   logic [XLEN-1:0] wb_data;
   logic [RIW-1:0]  dbg_idx;

   assign wb_data = memwb_q.result;

   assign id_op  = ifid_q.instr[OpcodeHi:OpcodeLo];
   assign id_rs  = ifid_q.instr[RsLo +: RIW];
   assign id_rt  = ifid_q.instr[RtLo +: RIW];
   assign id_rd  = ifid_q.instr[RdLo +: RIW];
   assign id_imm = XLEN'($signed(ifid_q.instr[ImmHi:ImmLo]));

   // Decode the ID instruction: class, destination and which sources it reads
   always_comb begin
      id_itype  = ifid_q.valid ? decode_itype(id_op) : NOP;
      id_dst    = '0;
      id_use_rs = 1'b0;
      id_use_rt = 1'b0;
      case (id_itype)
         RR_ALU: begin
            id_dst    = id_rd;
            id_use_rs = 1'b1;
            id_use_rt = 1'b1;
         end
         RM_ALU, LOAD: begin
            id_dst    = id_rt;
            id_use_rs = 1'b1;
         end
         STORE: begin
            id_use_rs = 1'b1;
            id_use_rt = 1'b1;
         end
         BRANCH:  id_use_rs = 1'b1;
         default: ;
      endcase
      id_wr     = (id_dst != '0);
      id_is_hlt = (id_itype == HALT);
   end

   // Register read with write-through from the WB stage; R0 is never written
   always_comb begin
      id_a = (memwb_q.wr && (memwb_q.dst == id_rs)) ? wb_data : regs_q[id_rs];
      id_b = (memwb_q.wr && (memwb_q.dst == id_rt)) ? wb_data : regs_q[id_rt];
   end

   // Assemble the ID/EX payload
   always_comb begin
      id_dec        = IdexBubble;
      id_dec.itype  = id_itype;
      id_dec.opcode = id_op;
      id_dec.rs     = id_rs;
      id_dec.rt     = id_rt;
      id_dec.dst    = id_dst;
      id_dec.wr     = id_wr;
      id_dec.a      = id_a;
      id_dec.b      = id_b;
      id_dec.imm    = id_imm;
      id_dec.npc    = ifid_q.npc;
   end

   risc_mips_hazard #(
      .RIW (RIW)
   ) u_hazard (
      .id_rs     (id_rs),
      .id_rt     (id_rt),
      .id_use_rs (id_use_rs),
      .id_use_rt (id_use_rt),
      .ex_load   (idex_q.itype == LOAD),
      .ex_wr     (idex_q.wr),
      .ex_dst    (idex_q.dst),
      .ex_rs     (idex_q.rs),
      .ex_rt     (idex_q.rt),
      .mem_wr    (exmem_q.wr),
      .mem_dst   (exmem_q.dst),
      .wb_wr     (memwb_q.wr),
      .wb_dst    (memwb_q.dst),
      .ex_taken  (ex_taken),
      .fwd_a     (fwd_a),
      .fwd_b     (fwd_b),
      .stall     (stall),
      .flush     (flush)
   );

   // EX operand muxes
   always_comb begin
      case (fwd_a)
         FwdExMem: ex_a = exmem_q.alu;
         FwdMemWb: ex_a = wb_data;
         default:  ex_a = idex_q.a;
      endcase
      case (fwd_b)
         FwdExMem: ex_b = exmem_q.alu;
         FwdMemWb: ex_b = wb_data;
         default:  ex_b = idex_q.b;
      endcase
      ex_op2 = (idex_q.itype == RR_ALU) ? ex_b : idex_q.imm;
   end

   // ALU and branch resolution; loads and stores compute rs + imm
   always_comb begin
      case (idex_q.opcode)
         OpAdd, OpAddi, OpLw, OpSw: ex_alu = ex_a + ex_op2;
         OpSub, OpSubi:             ex_alu = ex_a - ex_op2;
         OpAnd:                     ex_alu = ex_a & ex_op2;
         OpOr:                      ex_alu = ex_a | ex_op2;
         OpSlt, OpSlti:             ex_alu = XLEN'($signed(ex_a) < $signed(ex_op2));
         OpMul:                     ex_alu = ex_a * ex_op2;
         default:                   ex_alu = '0;
      endcase
      ex_taken  = (idex_q.itype == BRANCH) &&
                  ((idex_q.opcode == OpBeqz) ? (ex_a == '0) : (ex_a != '0));
      ex_target = idex_q.npc + idex_q.imm[AW-1:0];
   end

   // MEM stage: data memory access
   always_comb begin
      mem_result     = (exmem_q.itype == LOAD) ? bus.dmem_rdata : exmem_q.alu;
      bus.dmem_addr  = exmem_q.alu[AW-1:0];
      bus.dmem_wdata = exmem_q.sdata;
      bus.dmem_we    = (exmem_q.itype == STORE);
      bus.imem_addr  = pc_q;
   end

   // Next-state of PC and pipeline registers: flush beats stall beats halt
   always_comb begin
      pc_d   = pc_q;
      ifid_d = ifid_q;
      idex_d = id_dec;
      stop_d = stop_q;

      exmem_d       = ExmemBubble;
      exmem_d.itype = idex_q.itype;
      exmem_d.wr    = idex_q.wr;
      exmem_d.dst   = idex_q.dst;
      exmem_d.alu   = ex_alu;
      exmem_d.sdata = ex_b;

      memwb_d        = MemwbBubble;
      memwb_d.itype  = exmem_q.itype;
      memwb_d.wr     = exmem_q.wr;
      memwb_d.dst    = exmem_q.dst;
      memwb_d.result = mem_result;

      if (flush) begin
         pc_d   = ex_target;
         ifid_d = IfidBubble;
         idex_d = IdexBubble;
      end else if (stall) begin
         idex_d = IdexBubble;
      end else if (stop_q || id_is_hlt) begin
         // HLT has been decoded: stop fetching and hold PC
         ifid_d = IfidBubble;
         stop_d = 1'b1;
      end else begin
         pc_d         = pc_q + AW'(1);
         ifid_d.valid = 1'b1;
         ifid_d.instr = bus.imem_rdata;
         ifid_d.npc   = pc_q + AW'(1);
      end
   end

   // Pipeline registers, PC and halt flag; everything freezes once halted
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         pc_q     <= '0;
         ifid_q   <= IfidBubble;
         idex_q   <= IdexBubble;
         exmem_q  <= ExmemBubble;
         memwb_q  <= MemwbBubble;
         stop_q   <= 1'b0;
         halted_q <= 1'b0;
      end else if (!halted_q) begin
         pc_q     <= pc_d;
         ifid_q   <= ifid_d;
         idex_q   <= idex_d;
         exmem_q  <= exmem_d;
         memwb_q  <= memwb_d;
         stop_q   <= stop_d;
         halted_q <= (memwb_q.itype == HALT);
      end
   end

   // Register file write from WB
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int unsigned i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
      end else if (!halted_q && memwb_q.wr) begin
         regs_q[memwb_q.dst] <= wb_data;
      end
   end

   // Debug read port
   always_comb begin
      dbg_idx   = dbg_rsel[RIW-1:0];
      dbg_rdata = (dbg_idx == '0) ? '0 : regs_q[dbg_idx];
   end

   assign halted = halted_q;
   assign pc_out = pc_q;

endmodule

// File: tb/tb_risc_mips_pipe.sv
// Directed bench for risc_mips_pipe: small programs with hand-computed
// register, memory, PC and retire-cycle expectations, plus a reset-mid-store
// sequence and an XLEN=16 instance for the multiply wrap case.
module tb_risc_mips_pipe;

   localparam int AW = 10;

   localparam logic [5:0] TAdd = 6'b000000, TSub = 6'b000001, TAnd = 6'b000010;
   localparam logic [5:0] TOr = 6'b000011, TSlt = 6'b000100, TMul = 6'b000101;
   localparam logic [5:0] TLw = 6'b001000, TSw = 6'b001001, TAddi = 6'b001010;
   localparam logic [5:0] TSubi = 6'b001011, TSlti = 6'b001100;
   localparam logic [5:0] TBneqz = 6'b001101, TBeqz = 6'b001110;
   localparam logic [31:0] THlt = 32'hFC00_0000;

   localparam int KReg = 0, KCyc = 1, KMem = 2, KWe = 3, KPc = 4, KReg16 = 5;

   typedef struct {
      int          prog;
      int          kind;
      int          idx;
      logic [31:0] exp;
   } vec_t;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   logic mem_init = 1'b0;
   always #5 CLK = ~CLK;

   risc_mips_pipe_if #(.XLEN(32), .AW(AW)) bus ();
   risc_mips_pipe_if #(.XLEN(16), .AW(AW)) bus16 ();

   logic          halted, halted16;
   logic [AW-1:0] pc_out, pc_out16;
   logic [4:0]    dbg_rsel = 5'd0, dbg_rsel16 = 5'd0;
   logic [31:0]   dbg_rdata;
   logic [15:0]   dbg_rdata16;

   logic [31:0] imem   [1024];
   logic [31:0] dmem   [1024];
   logic [31:0] imem16 [1024];
   int          we_cnt;
   int          n_cmp = 0;
   int          n_fail = 0;
   int          cyc;
   vec_t        vecs[$];

   risc_mips_pipe #(.XLEN(32), .NREG(32), .AW(AW)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .bus       (bus),
      .halted    (halted),
      .pc_out    (pc_out),
      .dbg_rsel  (dbg_rsel),
      .dbg_rdata (dbg_rdata)
   );

   risc_mips_pipe #(.XLEN(16), .NREG(32), .AW(AW)) dut16 (
      .CLK       (CLK),
      .RST       (RST),
      .bus       (bus16),
      .halted    (halted16),
      .pc_out    (pc_out16),
      .dbg_rsel  (dbg_rsel16),
      .dbg_rdata (dbg_rdata16)
   );

   assign bus.imem_rdata   = imem[bus.imem_addr];
   assign bus.dmem_rdata   = dmem[bus.dmem_addr];
   assign bus16.imem_rdata = imem16[bus16.imem_addr];
   assign bus16.dmem_rdata = 16'h0;

   // Data memory model with store-pulse counter; mem_init clears it
   always @(posedge CLK) begin
      if (mem_init) begin
         foreach (dmem[i]) dmem[i] = 32'h0;
         dmem[5] = 32'd7;
         we_cnt  = 0;
      end else if (bus.dmem_we) begin
         dmem[bus.dmem_addr] = bus.dmem_wdata;
         we_cnt++;
      end
   end

   function automatic logic [31:0] rr(input logic [5:0] op, input int rd, input int rs,
                                      input int rt);
      return {op, rs[4:0], rt[4:0], rd[4:0], 11'b0};
   endfunction

   function automatic logic [31:0] ri(input logic [5:0] op, input int rt, input int rs,
                                      input int imm);
      return {op, rs[4:0], rt[4:0], imm[15:0]};
   endfunction

   function automatic string kname(input int k);
      case (k)
         KReg:    return "reg";
         KCyc:    return "halt_cycle";
         KMem:    return "dmem";
         KWe:     return "we_pulses";
         KPc:     return "pc";
         default: return "reg16";
      endcase
   endfunction

   task automatic load_prog(input int p);
      foreach (imem[i]) imem[i] = THlt;
      case (p)
         0: begin
            imem[0] = ri(TAddi, 1, 0, 10);
            imem[1] = ri(TAddi, 2, 0, 20);
            imem[2] = rr(TAdd, 3, 1, 2);
         end
         1: begin
            imem[0] = ri(TLw, 4, 0, 5);
            imem[1] = rr(TAdd, 5, 4, 4);
         end
         2: begin
            imem[0] = ri(TAddi, 1, 0, 3);
            imem[1] = ri(TSubi, 1, 1, 1);
            imem[2] = ri(TBneqz, 0, 1, -2);
            imem[3] = ri(TAddi, 6, 6, 1);
            imem[4] = ri(TAddi, 7, 7, 1);
         end
         3: begin
            imem[0] = ri(TAddi, 1, 0, -1);
            imem[1] = ri(TSlti, 2, 1, 0);
            imem[2] = ri(TSw, 2, 0, 9);
         end
         4: begin
            imem[0]  = ri(TAddi, 1, 0, 7);
            imem[1]  = ri(TAddi, 2, 0, -3);
            imem[2]  = rr(TSub, 3, 1, 2);
            imem[3]  = rr(TAnd, 4, 1, 2);
            imem[4]  = rr(TOr, 5, 1, 2);
            imem[5]  = rr(TSlt, 6, 2, 1);
            imem[6]  = rr(TSlt, 7, 1, 2);
            imem[7]  = rr(TMul, 8, 1, 2);
            imem[8]  = ri(TAddi, 0, 0, 5);
            imem[9]  = ri(TSubi, 10, 0, -32768);
            imem[10] = ri(TBeqz, 0, 0, 1);
            imem[11] = ri(TAddi, 11, 0, 99);
            imem[12] = ri(TAddi, 12, 0, 5);
            imem[13] = rr(6'b010000, 13, 1, 1);
         end
         default: begin
            imem[0] = ri(TBeqz, 0, 0, 2);
            imem[1] = THlt;
            imem[2] = ri(TAddi, 1, 0, 1);
            imem[3] = ri(TAddi, 2, 0, 2);
         end
      endcase
   endtask

   task automatic run_to_halt(input string tag);
      cyc = 0;
      while (!halted && cyc < 100) begin
         @(posedge CLK);
         cyc++;
         @(negedge CLK);
      end
      n_cmp++;
      if (!halted) begin
         n_fail++;
         $display("FAIL %s: halted=%0b after %0d cycles, required 1", tag, halted, cyc);
      end
   endtask

   task automatic run_prog(input int p);
      @(negedge CLK);
      RST      = 1'b1;
      mem_init = 1'b1;
      load_prog(p);
      @(negedge CLK);
      mem_init = 1'b0;
      @(negedge CLK);
      RST = 1'b0;
      run_to_halt($sformatf("halt_p%0d", p));
   endtask

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic check(input vec_t v);
      logic [31:0] act;
      case (v.kind)
         KReg: begin
            dbg_rsel = v.idx[4:0];
            #1 act = dbg_rdata;
         end
         KReg16: begin
            dbg_rsel16 = v.idx[4:0];
            #1 act = {16'h0, dbg_rdata16};
         end
         KCyc:    act = cyc;
         KMem:    act = dmem[v.idx];
         KWe:     act = we_cnt;
         default: act = 32'(pc_out);
      endcase
      cmp($sformatf("%s p%0d[%0d]", kname(v.kind), v.prog, v.idx), act, v.exp);
   endtask

   task automatic add(input int p, input int k, input int i, input logic [31:0] e);
      vec_t v;
      v = '{p, k, i, e};
      vecs.push_back(v);
   endtask

   initial begin
      int cur;
      foreach (imem16[i]) imem16[i] = THlt;
      imem16[0] = ri(TAddi, 1, 0, 300);
      imem16[1] = rr(TMul, 2, 1, 1);

      // Back-to-back ALU dependencies, no stall
      add(0, KReg, 1, 32'd10);        add(0, KReg, 2, 32'd20);
      add(0, KReg, 3, 32'd30);        add(0, KReg, 0, 32'd0);
      add(0, KCyc, 0, 32'd8);         add(0, KPc, 0, 32'd4);
      add(0, KReg16, 1, 32'd300);     add(0, KReg16, 2, 32'h5F90);
      // Load-use: one stall cycle
      add(1, KReg, 4, 32'd7);         add(1, KReg, 5, 32'd14);
      add(1, KCyc, 0, 32'd8);
      // Counted loop with taken-branch flushes
      add(2, KReg, 1, 32'd0);         add(2, KReg, 6, 32'd1);
      add(2, KReg, 7, 32'd1);         add(2, KCyc, 0, 32'd18);
      add(2, KPc, 0, 32'd6);
      // Signed compare feeding a store
      add(3, KReg, 1, 32'hFFFF_FFFF); add(3, KReg, 2, 32'd1);
      add(3, KMem, 9, 32'd1);         add(3, KWe, 0, 32'd1);
      add(3, KCyc, 0, 32'd8);
      // ALU ops, R0 write discard, branch skip, unknown opcode
      add(4, KReg, 3, 32'd10);        add(4, KReg, 4, 32'd5);
      add(4, KReg, 5, 32'hFFFF_FFFF); add(4, KReg, 6, 32'd1);
      add(4, KReg, 7, 32'd0);         add(4, KReg, 8, 32'hFFFF_FFEB);
      add(4, KReg, 0, 32'd0);         add(4, KReg, 10, 32'h0000_8000);
      add(4, KReg, 11, 32'd0);        add(4, KReg, 12, 32'd5);
      add(4, KReg, 13, 32'd0);        add(4, KCyc, 0, 32'd20);
      add(4, KPc, 0, 32'd15);
      // HLT in ID squashed by an older taken branch
      add(5, KReg, 1, 32'd0);         add(5, KReg, 2, 32'd2);
      add(5, KCyc, 0, 32'd9);         add(5, KPc, 0, 32'd5);

      cur = -1;
      foreach (vecs[i]) begin
         if (vecs[i].prog != cur) begin
            run_prog(vecs[i].prog);
            cur = vecs[i].prog;
         end
         check(vecs[i]);
      end

      // Reset while the SW sits in MEM: no store, everything back to reset state
      @(negedge CLK);
      RST      = 1'b1;
      mem_init = 1'b1;
      load_prog(3);
      @(negedge CLK);
      mem_init = 1'b0;
      @(negedge CLK);
      RST = 1'b0;
      cyc = 0;
      while (!bus.dmem_we && cyc < 50) begin
         @(posedge CLK);
         cyc++;
         @(negedge CLK);
      end
      cmp("sw_in_mem_cycle", cyc, 32'd5);
      RST      = 1'b1;
      dbg_rsel = 5'd1;
      #1;
      cmp("rst_dmem_we", {31'h0, bus.dmem_we}, 32'd0);
      cmp("rst_halted", {31'h0, halted}, 32'd0);
      cmp("rst_pc", 32'(pc_out), 32'd0);
      cmp("rst_r1", dbg_rdata, 32'd0);
      @(negedge CLK);
      cmp("rst_no_store", dmem[9], 32'd0);
      cmp("rst_we_pulses", we_cnt, 32'd0);
      @(negedge CLK);
      RST = 1'b0;
      run_to_halt("halt_restart");
      cmp("restart_cycle", cyc, 32'd8);
      cmp("restart_dmem9", dmem[9], 32'd1);
      cmp("restart_we_pulses", we_cnt, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/risc_mips_pipe.md
RISC_MIPS_PIPE -- requirements
Module: risc_mips_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath and register width (16..64).
REQ-002 SHALL have parameter NREG, default 32, meaning register count; a power of 2 from 8 to 32; register index = low log2(NREG) bits of each 5-bit field.
REQ-003 SHALL have parameter AW, default 10, meaning word-address width of instruction and data memory.
REQ-004 SHALL have port CLK  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port RST  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port imem_addr  output  AW  fetch word address, equal to PC.
REQ-007 SHALL have port imem_rdata  input  32  instruction at imem_addr, combinational, same cycle.
REQ-008 SHALL have port dmem_addr  output  AW  load/store word address.
REQ-009 SHALL have port dmem_wdata  output  XLEN  store data.
REQ-010 SHALL have port dmem_we  output  1  store strobe, one cycle per SW.
REQ-011 SHALL have port dmem_rdata  input  XLEN  load data, combinational, same cycle.
REQ-012 SHALL have port halted  output  1  high once HLT retires, sticky until RST.
REQ-013 SHALL have port pc_out  output  AW  current PC.
REQ-014 SHALL have port dbg_rsel  input  5  register select for debug read.
REQ-015 SHALL have port dbg_rdata  output  XLEN  combinational register-file read of dbg_rsel; 0 for R0.

Function
REQ-016 Pipeline SHALL have five single-clock stages: IF, ID, EX, MEM, WB.
REQ-017 ISA SHALL be ADD 000000, SUB 000001, AND 000010, OR 000011, SLT 000100, MUL 000101, LW 001000, SW 001001, ADDI 001010, SUBI 001011, SLTI 001100, BNEQZ 001101, BEQZ 001110, HLT 111111. Any other opcode SHALL execute as NOP.
REQ-018 Fields SHALL be opcode[31:26], rs[25:21], rt[20:16], rd[15:11] and imm[15:0]; imm SHALL be sign-extended to XLEN.
REQ-019 Results:
- Arithmetic SHALL wrap modulo 2^XLEN.
- MUL SHALL keep the low XLEN bits.
- SLT/SLTI SHALL compare signed and return 1 or 0.
REQ-020 Write-back destinations:
- RR ops SHALL write rd.
- RM ops and LW SHALL write rt.
- R0 SHALL read 0, and writes to R0 SHALL be discarded.
REQ-021 The register file SHALL be write-through: a same-cycle WB write SHALL be visible to the ID read.
REQ-022 Forwarding SHALL feed both EX operands, including SW store data, from EX/MEM first and then MEM/WB, with no stall for ALU-to-ALU dependencies.
REQ-023 Load-use: when the ID instruction reads the rt of an LW in EX, the block SHALL hold PC and IF/ID for 1 cycle and insert 1 bubble into EX.
REQ-024 Branches SHALL resolve in EX:
- Target = (NPC + imm) mod 2^AW, where NPC = PC of the branch + 1.
- BEQZ is taken when rs == 0; BNEQZ is taken when rs != 0.
- On a taken branch, the block SHALL flush IF/ID and ID/EX (2 bubbles) and load PC with the target on the next edge.
REQ-025 A flushed instruction SHALL never assert dmem_we and SHALL never write the register file.
REQ-026 When HLT is decoded, fetch SHALL stop and PC SHALL freeze.
REQ-027 Instructions older than HLT SHALL complete; halted SHALL rise on the edge HLT leaves WB.
REQ-028 After halted, no state SHALL change until reset.
REQ-029 A HLT in ID flushed by an older taken branch SHALL be ignored.
REQ-030 PC SHALL wrap from 2^AW-1 to 0.
REQ-031 dmem_we SHALL be asserted only while a valid SW is in MEM.
REQ-032 dmem_addr SHALL be rs + imm truncated to AW.

Reset
REQ-033 On RST, the block SHALL immediately drive PC=0, halted=0, dmem_we=0, all pipeline stages NOP and all registers 0.
REQ-034 Reset asserted mid-operation SHALL abort all in-flight instructions with no partial store.
REQ-035 Fetch of address 0 SHALL start on the first CLK edge after RST deasserts.

Structure
REQ-036 Package risc_mips_pkg SHALL hold the opcode constants, the instruction-type encoding (RR_ALU, RM_ALU, LOAD, STORE, BRANCH, HALT, NOP) and the field-position constants.
REQ-037 Forward-select and stall/flush logic SHALL be a combinational sub-module named risc_mips_hazard.
REQ-038 Register file and pipeline registers SHALL stay in the top module.

Verification
REQ-039 Scenario: ADDI R1,R0,10; ADDI R2,R0,20; ADD R3,R1,R2 back-to-back -> R3=30 with no stall, HLT retires at cycle 8 after reset.
REQ-040 Scenario: dmem[5]=7; LW R4,5(R0); ADD R5,R4,R4 -> exactly 1 stall cycle, R5=14.
REQ-041 Scenario: loop R1=3; SUBI R1,R1,1; BNEQZ R1,-2 -> body executes 3 times, the two instructions after the branch never write, final R1=0.
REQ-042 Scenario: ADDI R1,R0,-1; SLTI R2,R1,0; SW R2,9(R0) -> dmem[9]=1, dmem_we pulses exactly once.
REQ-043 Scenario: XLEN=16, MUL of 300 by 300 -> low 16 bits of 90000 (0x5F90).
REQ-044 Scenario: RST asserted during the cycle SW is in MEM -> dmem_we low, all outputs at reset values, program restarts from 0.
